neuro_layer_sequencer: RTL and testbench
========================================

# neuro_layer_sequencer

Hardware scheduler placed in front of the NeuroSpider core's register bus. It accepts neuron descriptors from a queue and, for each one, programs the core's configuration registers and pulses `StartOperation`. It then waits for `ReadyNextOperation` and repeats, so a whole layer runs without host intervention. While it is idle it shares the core bus with the host, which needs direct access for cache-router selection, cache loads and result reads.

## Interface
- `DEPTH`, 4: descriptor FIFO entries (power of 2).
- `BUSY_TIMEOUT`, 8: maximum cycles in WAIT_BUSY for the core to drop ready.
- `DONE_TIMEOUT`, 1024: maximum cycles in WAIT_DONE.
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `desc_valid` in 1 / `desc_ready` out 1: descriptor push handshake; a push occurs when both are high.
- `desc_input_off`, `desc_weight_off`, `desc_index_off`, `desc_dest`, `desc_num_ops`, `desc_ctrl` in 16 each: descriptor fields.
- `host_we` in 1, `host_addr` in 16, `host_wdata` in 16: host bus.
- `host_gnt` out 1: host currently owns the core bus.
- `core_we` out 1, `core_addr` out 16, `core_wdata` out 16, `core_start` out 1: drive the core's `WE`/`Address`/`DataWrite`/`StartOperation`.
- `core_ready` in 1: the core's `ReadyNextOperation`.
- `busy` out 1: state ≠ IDLE.
- `neurons_done` out 16: count of completed neurons.
- `timeout_err` out 1: sticky error flag.
- `clear_err` in 1: clears `timeout_err`.

## Operation
- FIFO: `desc_ready = !full`. A push while full is impossible by handshake. Pop occurs on the START→WAIT_BUSY transition.
- FSM states: IDLE, PROG, START, WAIT_BUSY, WAIT_DONE.
- IDLE → PROG when the FIFO is not empty and `timeout_err`=0. The step index resets to 0.
- PROG, one register write per cycle, `core_we`=1, data taken from the FIFO head. The fixed order is:
  - step 0: 0x8000 ← `input_off`
  - step 1: 0x8006 ← `weight_off`
  - step 2: 0x8005 ← `index_off`
  - step 3: 0x8001 ← `dest`
  - step 4: 0x8002 ← `num_ops`
  - step 5: 0x8004 ← `ctrl`
  - After step 5 the FSM goes to START.
- 0x8003 (cache router) is never written by the sequencer; it is host-only.
- START: one cycle with `core_start`=1, `core_we`=0, `core_addr`=0. Then WAIT_BUSY.
- WAIT_BUSY:
  - `core_ready`=0 → WAIT_DONE.
  - `BUSY_TIMEOUT` cycles elapse with `core_ready` still 1 → set `timeout_err`, go to IDLE.
- WAIT_DONE:
  - `core_ready`=1 → IDLE, and `neurons_done` increments (wraps 0xFFFF→0).
  - `DONE_TIMEOUT` cycles elapse → set `timeout_err`, go to IDLE.
- Timeout: the descriptor is already popped and is discarded. The FIFO contents are kept. Dequeue stalls until `clear_err`.
- `clear_err` and a new timeout in the same cycle: the set wins.
- Arbitration: `host_gnt = (state==IDLE) && (fifo_empty || timeout_err)`.
  - When granted, `core_we`/`core_addr`/`core_wdata` = host bus and `core_start`=0.
  - When not granted, host writes are dropped silently.
- A push and a host write in the same idle cycle: the host write goes through. The sequencer takes the bus from the next cycle.
- Outside PROG, and when not granted, the sequencer drives `core_we`=0, `core_addr`=0, `core_wdata`=0.

## Timing
- Reset values: state IDLE, FIFO empty, `desc_ready`=1, `host_gnt`=1, `busy`=0, `core_*`=0 (or host pass-through, since `host_gnt`=1), `neurons_done`=0, `timeout_err`=0.
- Push at edge E0 into an empty FIFO while IDLE:
  - IDLE → PROG at E1.
  - Step-0 write is visible between E1 and E2.
  - Step 5 between E6 and E7.
  - START between E7 and E8.
  - `host_gnt` falls after E1.
- Back-to-back descriptors: the next PROG begins the cycle after WAIT_DONE→IDLE (one IDLE cycle). The host is not granted in that cycle.
- `rst` mid-operation aborts immediately: the FIFO is flushed and counters are zeroed. The core itself is not reset by this block; a START already issued is not revoked.

## Structure
- Package `neuro_seq_pkg` holds:
  - core register address constants 0x8000–0x8006;
  - the state enum;
  - the `neuron_desc_t` struct (six 16-bit fields, 96 bits);
  - the PROG step count (6).
- Sub-module `neuro_desc_fifo`: synchronous FIFO of `neuron_desc_t`, `DEPTH` entries, with full/empty outputs.
- The top holds the FSM, the step and timeout counters, the error flag and the bus mux.

## Test plan
- Single descriptor (input_off 1, weight_off 1, index_off 1, dest 1, num_ops 2, ctrl 0); core model drops ready 1 cycle after start and raises it 20 cycles later → the six writes appear in the exact address/data order, then one start pulse; `neurons_done`=1; `host_gnt` returns to 1.
- Four descriptors pushed back-to-back with DEPTH=4 → `desc_ready` is 0 after the 4th push; all four execute in order; `neurons_done`=4.
- Host write 0x8003←0x0004 issued during PROG → not seen on the core bus; the same write while idle with the FIFO empty → passes through in the same cycle.
- Core model never drops ready → `timeout_err` is 1 after 8 cycles in WAIT_BUSY; the queued second descriptor is not started; after `clear_err` it executes.
- Assert `rst` during WAIT_DONE with 2 descriptors queued → the next cycle shows IDLE, FIFO empty, `neurons_done`=0, `host_gnt`=1.

Source files
------------

// File: rtl/neuro_seq_pkg.sv
// Shared definitions for the NeuroSpider layer sequencer: core register map,
// sequencer states, the neuron descriptor record and the programming order.
package neuro_seq_pkg;

  // NeuroSpider core configuration registers
  localparam logic [15:0] ADDR_INPUT_OFF    = 16'h8000;
  localparam logic [15:0] ADDR_DEST         = 16'h8001;
  localparam logic [15:0] ADDR_NUM_OPS      = 16'h8002;
  localparam logic [15:0] ADDR_CACHE_ROUTER = 16'h8003;  // host-only, never programmed here
  localparam logic [15:0] ADDR_CTRL         = 16'h8004;
  localparam logic [15:0] ADDR_INDEX_OFF    = 16'h8005;
  localparam logic [15:0] ADDR_WEIGHT_OFF   = 16'h8006;

  // Number of register writes issued per neuron
  localparam int PROG_STEPS = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROG,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } seq_state_t;

  typedef struct packed {
    logic [15:0] input_off;
    logic [15:0] weight_off;
    logic [15:0] index_off;
    logic [15:0] dest;
    logic [15:0] num_ops;
    logic [15:0] ctrl;
  } neuron_desc_t;

  // Register written at a given programming step
  function automatic logic [15:0] prog_addr(input logic [2:0] step);
    case (step)
      3'd0:    prog_addr = ADDR_INPUT_OFF;
      3'd1:    prog_addr = ADDR_WEIGHT_OFF;
      3'd2:    prog_addr = ADDR_INDEX_OFF;
      3'd3:    prog_addr = ADDR_DEST;
      3'd4:    prog_addr = ADDR_NUM_OPS;
      3'd5:    prog_addr = ADDR_CTRL;
      default: prog_addr = 16'h0000;
    endcase
  endfunction

  // Descriptor field written at a given programming step
  function automatic logic [15:0] prog_data(input neuron_desc_t d, input logic [2:0] step);
    case (step)
      3'd0:    prog_data = d.input_off;
      3'd1:    prog_data = d.weight_off;
      3'd2:    prog_data = d.index_off;
      3'd3:    prog_data = d.dest;
      3'd4:    prog_data = d.num_ops;
      3'd5:    prog_data = d.ctrl;
      default: prog_data = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/neuro_desc_fifo.sv
// Small synchronous descriptor queue. The head entry is read asynchronously so
// the sequencer can stream its fields onto the core bus without a read bubble.
module neuro_desc_fifo
  import neuro_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  neuron_desc_t data_i,
  output neuron_desc_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  neuron_desc_t   mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q;
  logic [AW:0]    rd_ptr_q;

  // Storage write; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  // Pointer update; the extra MSB tells full from empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/neuro_layer_sequencer.sv
// Layer sequencer: pulls neuron descriptors from a queue, programs the core's
// configuration registers, starts the core and waits for completion. The core
// bus is handed to the host whenever the sequencer has nothing it may run.
module neuro_layer_sequencer
  import neuro_seq_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 8,
  parameter int DONE_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        desc_valid,
  output logic        desc_ready,
  input  logic [15:0] desc_input_off,
  input  logic [15:0] desc_weight_off,
  input  logic [15:0] desc_index_off,
  input  logic [15:0] desc_dest,
  input  logic [15:0] desc_num_ops,
  input  logic [15:0] desc_ctrl,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_gnt,
  output logic        core_we,
  output logic [15:0] core_addr,
  output logic [15:0] core_wdata,
  output logic        core_start,
  input  logic        core_ready,
  output logic        busy,
  output logic [15:0] neurons_done,
  input  logic        clear_err,
  output logic        timeout_err
);

  localparam int TMAX = (DONE_TIMEOUT > BUSY_TIMEOUT) ? DONE_TIMEOUT : BUSY_TIMEOUT;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] BUSY_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [TW-1:0] DONE_LAST = TW'(DONE_TIMEOUT - 1);
  localparam logic [2:0]    STEP_LAST = 3'(PROG_STEPS - 1);

  seq_state_t   state_q;
  logic [2:0]   step_q;
  logic [TW-1:0] timer_q;
  logic         err_q;
  logic [15:0]  done_cnt_q;

  neuron_desc_t desc_in;
  neuron_desc_t fifo_head;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_push;
  logic         fifo_pop;

  assign desc_in.input_off  = desc_input_off;
  assign desc_in.weight_off = desc_weight_off;
  assign desc_in.index_off  = desc_index_off;
  assign desc_in.dest       = desc_dest;
  assign desc_in.num_ops    = desc_num_ops;
  assign desc_in.ctrl       = desc_ctrl;

  assign desc_ready = !fifo_full;
  assign fifo_push  = desc_valid && !fifo_full;
  // The descriptor leaves the queue as the core is launched; on a later
  // timeout it is therefore discarded rather than retried.
  assign fifo_pop   = (state_q == ST_START);

  neuro_desc_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (desc_in),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Sequencer FSM with step/timeout counters, sticky error and completion count
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      // A timeout raised below in the same cycle overrides this clear
      if (clear_err) err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty && !err_q) begin
            state_q <= ST_PROG;
            step_q  <= '0;
          end
        end
        ST_PROG: begin
          if (step_q == STEP_LAST) state_q <= ST_START;
          else                     step_q  <= step_q + 3'd1;
        end
        ST_START: begin
          state_q <= ST_WAIT_BUSY;
          timer_q <= '0;
        end
        ST_WAIT_BUSY: begin
          if (!core_ready) begin
            state_q <= ST_WAIT_DONE;
            timer_q <= '0;
          end else if (timer_q == BUSY_LAST) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (core_ready) begin
            state_q    <= ST_IDLE;
            done_cnt_q <= done_cnt_q + 16'd1;
          end else if (timer_q == DONE_LAST) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign host_gnt     = (state_q == ST_IDLE) && (fifo_empty || err_q);
  assign busy         = (state_q != ST_IDLE);
  assign neurons_done = done_cnt_q;
  assign timeout_err  = err_q;

  // Core bus mux: host pass-through when granted, otherwise sequencer drive
  always_comb begin
    core_we    = 1'b0;
    core_addr  = 16'h0000;
    core_wdata = 16'h0000;
    core_start = 1'b0;
    if (host_gnt) begin
      core_we    = host_we;
      core_addr  = host_addr;
      core_wdata = host_wdata;
    end else if (state_q == ST_PROG) begin
      core_we    = 1'b1;
      core_addr  = prog_addr(step_q);
      core_wdata = prog_data(fifo_head, step_q);
    end else if (state_q == ST_START) begin
      core_start = 1'b1;
    end
  end

endmodule

// File: tb/tb_neuro_layer_sequencer.sv
// Self-checking bench for neuro_layer_sequencer: host pass-through vectors,
// a scoreboard of expected core-bus writes per descriptor, timeout and reset.
module tb_neuro_layer_sequencer;
  import neuro_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [15:0] desc_input_off = '0, desc_weight_off = '0, desc_index_off = '0;
  logic [15:0] desc_dest = '0, desc_num_ops = '0, desc_ctrl = '0;
  logic        host_we = 1'b0;
  logic [15:0] host_addr = '0, host_wdata = '0;
  logic        host_gnt;
  logic        core_we;
  logic [15:0] core_addr, core_wdata;
  logic        core_start;
  logic        core_ready = 1'b1;
  logic        busy;
  logic [15:0] neurons_done;
  logic        clear_err = 1'b0;
  logic        timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  neuro_layer_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .desc_valid      (desc_valid),
    .desc_ready      (desc_ready),
    .desc_input_off  (desc_input_off),
    .desc_weight_off (desc_weight_off),
    .desc_index_off  (desc_index_off),
    .desc_dest       (desc_dest),
    .desc_num_ops    (desc_num_ops),
    .desc_ctrl       (desc_ctrl),
    .host_we         (host_we),
    .host_addr       (host_addr),
    .host_wdata      (host_wdata),
    .host_gnt        (host_gnt),
    .core_we         (core_we),
    .core_addr       (core_addr),
    .core_wdata      (core_wdata),
    .core_start      (core_start),
    .core_ready      (core_ready),
    .busy            (busy),
    .neurons_done    (neurons_done),
    .clear_err       (clear_err),
    .timeout_err     (timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Core model: drops ready the cycle after a start pulse, raises it 20 cycles later
  bit never_drop = 1'b0;
  bit cm_act = 1'b0;
  int cm_cnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      core_ready <= 1'b1;
      cm_act     <= 1'b0;
      cm_cnt     <= 0;
    end else if (core_start && !never_drop) begin
      core_ready <= 1'b0;
      cm_act     <= 1'b1;
      cm_cnt     <= 0;
    end else if (cm_act) begin
      if (cm_cnt == 19) begin
        core_ready <= 1'b1;
        cm_act     <= 1'b0;
      end else begin
        cm_cnt <= cm_cnt + 1;
      end
    end
  end

  // Scoreboard of sequencer-driven bus cycles, in issue order
  typedef struct {
    logic        is_start;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;
  exp_t expq[$];
  exp_t mon_e;

  task automatic expect_desc(input logic [15:0] a, w, x, d, n, c);
    exp_t e;
    logic [15:0] addrs [6];
    logic [15:0] datas [6];
    addrs = '{16'h8000, 16'h8006, 16'h8005, 16'h8001, 16'h8002, 16'h8004};
    datas = '{a, w, x, d, n, c};
    for (int i = 0; i < 6; i++) begin
      e.is_start = 1'b0; e.addr = addrs[i]; e.data = datas[i];
      expq.push_back(e);
    end
    e.is_start = 1'b1; e.addr = 16'h0000; e.data = 16'h0000;
    expq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (!host_gnt && (core_we || core_start)) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_bus: we=%0b start=%0b addr=%h data=%h required no activity",
                   core_we, core_start, core_addr, core_wdata);
        end else begin
          mon_e = expq.pop_front();
          check("bus_start", {31'd0, core_start}, {31'd0, mon_e.is_start});
          check("bus_we", {31'd0, core_we}, {31'd0, !mon_e.is_start});
          check("bus_addr", {16'd0, core_addr}, {16'd0, mon_e.addr});
          check("bus_data", {16'd0, core_wdata}, {16'd0, mon_e.data});
        end
      end
      check("gnt_while_busy", {31'd0, host_gnt && busy}, 32'd0);
    end
  end

  task automatic push_desc(input logic [15:0] a, w, x, d, n, c);
    desc_input_off = a; desc_weight_off = w; desc_index_off = x;
    desc_dest = d; desc_num_ops = n; desc_ctrl = c;
    desc_valid = 1'b1;
    check("push_ready", {31'd0, desc_ready}, 32'd1);
    expect_desc(a, w, x, d, n, c);
    tick(1);
    desc_valid = 1'b0;
  endtask

  task automatic push_rand();
    push_desc(16'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic wait_start(input int budget, input string name);
    int i;
    i = 0;
    while (core_start !== 1'b1 && i < budget) begin
      tick(1);
      i++;
    end
    check(name, {31'd0, core_start}, 32'd1);
  endtask

  task automatic wait_done(input logic [15:0] target, input int budget, input string name);
    int i;
    i = 0;
    while (neurons_done !== target && i < budget) begin
      tick(1);
      i++;
    end
    check(name, {16'd0, neurons_done}, {16'd0, target});
  endtask

  // Host pass-through vectors applied while idle with an empty queue
  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
    logic        exp_we;
    logic [15:0] exp_addr;
    logic [15:0] exp_data;
  } vec_t;
  vec_t vecs [4];

  initial begin
    vecs[0] = '{1'b1, 16'h8003, 16'h0004, 1'b1, 16'h8003, 16'h0004};
    vecs[1] = '{1'b0, 16'h8000, 16'h1234, 1'b0, 16'h8000, 16'h1234};
    vecs[2] = '{1'b1, 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 16'hFFFF};
    vecs[3] = '{1'b1, 16'h8006, 16'hA5A5, 1'b1, 16'h8006, 16'hA5A5};

    // Reset state
    tick(3);
    rst = 1'b0;
    check("rst_desc_ready", {31'd0, desc_ready}, 32'd1);
    check("rst_host_gnt", {31'd0, host_gnt}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_neurons_done", {16'd0, neurons_done}, 32'd0);
    check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    check("rst_core_we", {31'd0, core_we}, 32'd0);
    check("rst_core_start", {31'd0, core_start}, 32'd0);

    // Table-driven host pass-through
    for (int i = 0; i < 4; i++) begin
      host_we = vecs[i].we; host_addr = vecs[i].addr; host_wdata = vecs[i].data;
      #1;
      check("vec_core_we", {31'd0, core_we}, {31'd0, vecs[i].exp_we});
      check("vec_core_addr", {16'd0, core_addr}, {16'd0, vecs[i].exp_addr});
      check("vec_core_wdata", {16'd0, core_wdata}, {16'd0, vecs[i].exp_data});
      check("vec_core_start", {31'd0, core_start}, 32'd0);
      tick(1);
    end
    // Random host traffic while granted must pass straight through
    for (int i = 0; i < 8; i++) begin
      host_we = 1'($urandom); host_addr = 16'($urandom); host_wdata = 16'($urandom);
      #1;
      check("rnd_pass_we", {31'd0, core_we}, {31'd0, host_we});
      check("rnd_pass_addr", {16'd0, core_addr}, {16'd0, host_addr});
      check("rnd_pass_wdata", {16'd0, core_wdata}, {16'd0, host_wdata});
      tick(1);
    end
    host_we = 1'b0; host_addr = '0; host_wdata = '0;

    // Single descriptor with exact timing; host write during PROG is dropped
    push_desc(16'd1, 16'd1, 16'd1, 16'd1, 16'd2, 16'd0);
    tick(1);
    check("t1_step0_we", {31'd0, core_we}, 32'd1);
    check("t1_step0_addr", {16'd0, core_addr}, 32'h8000);
    check("t1_step0_data", {16'd0, core_wdata}, 32'd1);
    check("t1_gnt_low", {31'd0, host_gnt}, 32'd0);
    host_we = 1'b1; host_addr = ADDR_CACHE_ROUTER; host_wdata = 16'h0004;
    tick(1);
    check("t1_host_dropped_addr", {16'd0, core_addr}, 32'h8006);
    tick(5);
    check("t1_start", {31'd0, core_start}, 32'd1);
    check("t1_start_we", {31'd0, core_we}, 32'd0);
    check("t1_start_addr", {16'd0, core_addr}, 32'd0);
    check("t1_start_wdata", {16'd0, core_wdata}, 32'd0);
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
    wait_done(16'd1, 200, "t1_neurons_done");
    tick(1);
    check("t1_gnt_back", {31'd0, host_gnt}, 32'd1);
    check("t1_idle", {31'd0, busy}, 32'd0);
    check("t1_sb_drained", expq.size(), 32'd0);

    // Four random descriptors back-to-back fill the queue
    for (int i = 0; i < 4; i++) push_rand();
    check("t2_full_ready", {31'd0, desc_ready}, 32'd0);
    wait_done(16'd5, 2000, "t2_neurons_done");
    tick(1);
    check("t2_sb_drained", expq.size(), 32'd0);
    check("t2_gnt_back", {31'd0, host_gnt}, 32'd1);

    // Core never drops ready: busy timeout, clear_err held high (set wins)
    never_drop = 1'b1;
    clear_err  = 1'b1;
    push_rand();
    push_rand();
    wait_start(40, "t3_first_start");
    tick(8);
    check("t3_err_before", {31'd0, timeout_err}, 32'd0);
    check("t3_busy_before", {31'd0, busy}, 32'd1);
    tick(1);
    check("t3_err_set", {31'd0, timeout_err}, 32'd1);
    check("t3_idle", {31'd0, busy}, 32'd0);
    clear_err = 1'b0;
    tick(20);
    check("t3_stalled", {31'd0, busy}, 32'd0);
    check("t3_second_pending", expq.size(), 32'd7);
    check("t3_done_unchanged", {16'd0, neurons_done}, 32'd5);
    check("t3_gnt_err", {31'd0, host_gnt}, 32'd1);
    host_we = 1'b1; host_addr = ADDR_CACHE_ROUTER; host_wdata = 16'h0004;
    #1;
    check("t3_host_pass_addr", {16'd0, core_addr}, 32'h8003);
    check("t3_host_pass_we", {31'd0, core_we}, 32'd1);
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
    never_drop = 1'b0;
    clear_err  = 1'b1;
    tick(1);
    clear_err  = 1'b0;
    check("t3_err_cleared", {31'd0, timeout_err}, 32'd0);
    wait_done(16'd6, 400, "t3_neurons_done");
    tick(1);
    check("t3_sb_drained", expq.size(), 32'd0);

    // Reset during WAIT_DONE with two descriptors still queued
    push_rand();
    push_rand();
    push_rand();
    wait_start(40, "t4_start");
    tick(3);
    check("t4_in_wait_done", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick(1);
    check("t4_rst_busy", {31'd0, busy}, 32'd0);
    check("t4_rst_ready", {31'd0, desc_ready}, 32'd1);
    check("t4_rst_gnt", {31'd0, host_gnt}, 32'd1);
    check("t4_rst_done", {16'd0, neurons_done}, 32'd0);
    check("t4_rst_err", {31'd0, timeout_err}, 32'd0);
    rst = 1'b0;
    expq.delete();
    tick(10);
    check("t4_flushed", {31'd0, busy}, 32'd0);
    check("t4_flushed_gnt", {31'd0, host_gnt}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
